// File: rtl/magic_adder_pipe.sv
// Two-stage pipelined magic adder: optional Gray-to-binary operand decode in
// stage 1, widened add with optional Gray re-encode in stage 2. Valid/ready
// streams on both sides with full throughput and backpressure.
module magic_adder_pipe #(
  parameter int unsigned W     = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             is_gray,
  input  logic             out_gray,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W:0]       sum,
  output logic [CNT_W-1:0] txn_count
);

  logic [W-1:0]     s1_a_q, s1_b_q;
  logic             s1_outg_q;
  logic             s1_valid_q;
  logic [W:0]       s2_sum_q;
  logic             s2_valid_q;
  logic [CNT_W-1:0] cnt_q;

  logic             s1_adv, s2_adv;
  logic [W-1:0]     a_bin, b_bin;
  logic [W:0]       sum_bin, sum_enc;

  // MSB passes through; each lower bit folds in the already-decoded bit above it.
  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] r;
    r[W-1] = g[W-1];
    for (int i = int'(W) - 2; i >= 0; i--) begin
      r[i] = r[i+1] ^ g[i];
    end
    return r;
  endfunction

  // Flow control: a stage may load when it is empty or its content is leaving.
  always_comb begin
    s2_adv    = !s2_valid_q || out_ready;
    s1_adv    = !s1_valid_q || s2_adv;
    in_ready  = s1_adv;
    out_valid = s2_valid_q;
    sum       = s2_sum_q;
    txn_count = cnt_q;
  end

  // Operand decode and widened add; the extra sum bit makes overflow impossible.
  always_comb begin
    a_bin   = is_gray ? gray2bin(a) : a;
    b_bin   = is_gray ? gray2bin(b) : b;
    sum_bin = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    sum_enc = s1_outg_q ? (sum_bin ^ (sum_bin >> 1)) : sum_bin;
  end

  // Pipeline registers and completed-transaction counter; reset wins over transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_outg_q  <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_a_q    <= a_bin;
          s1_b_q    <= b_bin;
          s1_outg_q <= out_gray;
        end
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_sum_q <= sum_enc;
        end
      end
      if (s2_valid_q && out_ready) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_magic_adder_pipe.sv
// Bench for magic_adder_pipe: directed W=3 cases, stall/drain, mid-stream reset,
// counter wrap with CNT_W=2, and a randomized W=8 run against a scoreboard.
module tb_magic_adder_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // W=3 instance; the CNT_W=2 instance shares its inputs
  logic        in_valid3, in_ready3, isg3, outg3, out_valid3, out_ready3;
  logic [2:0]  a3, b3;
  logic [3:0]  sum3;
  logic [15:0] cnt3;
  logic        in_ready_c, out_valid_c;
  logic [3:0]  sum_c;
  logic [1:0]  cnt_c;
  // W=8 instance
  logic        in_valid8, in_ready8, isg8, outg8, out_valid8, out_ready8;
  logic [7:0]  a8, b8;
  logic [8:0]  sum8;
  logic [15:0] cnt8;

  int n_vec = 0;
  int n_err = 0;

  magic_adder_pipe #(.W(3), .CNT_W(16)) u_d3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .a(a3), .b(b3),
    .is_gray(isg3), .out_gray(outg3), .out_valid(out_valid3), .out_ready(out_ready3),
    .sum(sum3), .txn_count(cnt3)
  );

  magic_adder_pipe #(.W(3), .CNT_W(2)) u_dc (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready_c), .a(a3), .b(b3),
    .is_gray(isg3), .out_gray(outg3), .out_valid(out_valid_c), .out_ready(out_ready3),
    .sum(sum_c), .txn_count(cnt_c)
  );

  magic_adder_pipe #(.W(8), .CNT_W(16)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .is_gray(isg8), .out_gray(outg8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .txn_count(cnt8)
  );

  // Gray decode as the XOR of all right shifts of the code word.
  function automatic int unsigned g2b(input int unsigned g);
    int unsigned r = 0;
    for (int s = 0; s < 32; s++) r ^= (g >> s);
    return r;
  endfunction

  function automatic int unsigned model(input int unsigned x, input int unsigned y,
                                        input bit ig, input bit og);
    int unsigned s;
    s = (ig ? g2b(x) : x) + (ig ? g2b(y) : y);
    return og ? (s ^ (s >> 1)) : s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid3 = 1'b0;
    in_valid8 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_vec++; if (out_valid3 !== 1'b0) begin n_err++; $display("FAIL rst_ov3 got %b want 0", out_valid3); end
    n_vec++; if (sum3 !== 4'd0) begin n_err++; $display("FAIL rst_sum3 got %h want 0", sum3); end
    n_vec++; if (cnt3 !== 16'd0) begin n_err++; $display("FAIL rst_cnt3 got %0d want 0", cnt3); end
    n_vec++; if (in_ready3 !== 1'b1) begin n_err++; $display("FAIL rst_ir3 got %b want 1", in_ready3); end
    n_vec++; if (out_valid8 !== 1'b0) begin n_err++; $display("FAIL rst_ov8 got %b want 0", out_valid8); end
    n_vec++; if (sum8 !== 9'd0) begin n_err++; $display("FAIL rst_sum8 got %h want 0", sum8); end
    n_vec++; if (in_ready8 !== 1'b1) begin n_err++; $display("FAIL rst_ir8 got %b want 1", in_ready8); end
    n_vec++;
    if (cnt_c !== 2'd0 || out_valid_c !== 1'b0 || sum_c !== 4'd0 || in_ready_c !== 1'b1) begin
      n_err++;
      $display("FAIL rst_dc got cnt=%0d ov=%b sum=%h ir=%b want 0 0 0 1",
               cnt_c, out_valid_c, sum_c, in_ready_c);
    end
  endtask

  // One transaction through the W=3 pipe with an idle output; checks exact latency.
  task automatic send3(input logic [2:0] xa, input logic [2:0] xb, input bit ig, input bit og,
                       input logic [3:0] exp, input string name);
    logic [15:0] c0;
    c0 = cnt3;
    in_valid3 = 1'b1; a3 = xa; b3 = xb; isg3 = ig; outg3 = og; out_ready3 = 1'b1;
    #1;
    n_vec++; if (in_ready3 !== 1'b1) begin n_err++; $display("FAIL %s_ir got %b want 1", name, in_ready3); end
    tick();
    in_valid3 = 1'b0;
    n_vec++; if (out_valid3 !== 1'b0) begin n_err++; $display("FAIL %s_early got ov=%b want 0", name, out_valid3); end
    tick();
    n_vec++;
    if (out_valid3 !== 1'b1 || sum3 !== exp) begin
      n_err++; $display("FAIL %s got ov=%b sum=%b want 1 %b", name, out_valid3, sum3, exp);
    end
    tick();
    n_vec++;
    if (out_valid3 !== 1'b0 || cnt3 !== c0 + 16'd1) begin
      n_err++; $display("FAIL %s_done got ov=%b cnt=%0d want 0 %0d", name, out_valid3, cnt3, c0 + 1);
    end
  endtask

  task automatic test_directed();
    send3(3'b001, 3'b010, 1'b0, 1'b0, 4'b0011, "bin_add");
    send3(3'b101, 3'b011, 1'b1, 1'b0, 4'b1000, "gray_in");
    send3(3'b111, 3'b111, 1'b1, 1'b0, 4'b1010, "gray_in_max");
    send3(3'b111, 3'b001, 1'b0, 1'b1, 4'b1100, "gray_out");
    send3(3'b111, 3'b111, 1'b0, 1'b0, 4'b1110, "bin_max");
  endtask

  task automatic test_back_to_back();
    logic [2:0] va [4];
    logic [2:0] vb [4];
    logic [3:0] ex [4];
    logic [3:0] held;
    int acc, got;
    va = '{3'd1, 3'd2, 3'd3, 3'd7};
    vb = '{3'd1, 3'd3, 3'd4, 3'd6};
    ex = '{4'd2, 4'd5, 4'd7, 4'd13};
    do_reset();
    out_ready3 = 1'b0; isg3 = 1'b0; outg3 = 1'b0; acc = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid3 = (acc < 4); a3 = va[acc % 4]; b3 = vb[acc % 4];
      #1;
      if (in_valid3 && in_ready3) acc++;
      tick();
    end
    #1;
    n_vec++; if (acc !== 2) begin n_err++; $display("FAIL bp_accepted got %0d want 2", acc); end
    n_vec++; if (in_ready3 !== 1'b0) begin n_err++; $display("FAIL bp_ir got %b want 0", in_ready3); end
    held = sum3;
    n_vec++; if (held !== ex[0]) begin n_err++; $display("FAIL bp_head got %h want %h", held, ex[0]); end
    for (int c = 0; c < 5; c++) begin
      tick();
      n_vec++;
      if (out_valid3 !== 1'b1 || sum3 !== held || in_ready3 !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold got ov=%b sum=%h ir=%b want 1 %h 0", out_valid3, sum3, in_ready3, held);
      end
    end
    out_ready3 = 1'b1; got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      in_valid3 = (acc < 4); a3 = va[acc % 4]; b3 = vb[acc % 4];
      #1;
      if (in_valid3 && in_ready3) acc++;
      if (out_valid3) begin
        n_vec++;
        if (sum3 !== ex[got]) begin n_err++; $display("FAIL bp_drain%0d got %h want %h", got, sum3, ex[got]); end
        got++;
      end
      tick();
    end
    in_valid3 = 1'b0;
    n_vec++; if (got !== 4) begin n_err++; $display("FAIL bp_got got %0d want 4", got); end
    n_vec++; if (cnt3 !== 16'd4) begin n_err++; $display("FAIL bp_cnt got %0d want 4", cnt3); end
  endtask

  task automatic test_reset_mid();
    int acc;
    out_ready3 = 1'b0; isg3 = 1'b0; outg3 = 1'b0; a3 = 3'd5; b3 = 3'd6; acc = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid3 = 1'b1;
      #1;
      if (in_ready3) acc++;
      tick();
    end
    n_vec++; if (acc !== 2) begin n_err++; $display("FAIL rm_fill got %0d want 2", acc); end
    rst = 1'b1; in_valid3 = 1'b1; out_ready3 = 1'b1;
    tick();
    rst = 1'b0; in_valid3 = 1'b0;
    #1;
    n_vec++;
    if (out_valid3 !== 1'b0 || sum3 !== 4'd0 || cnt3 !== 16'd0 || in_ready3 !== 1'b1) begin
      n_err++;
      $display("FAIL rm_state got ov=%b sum=%h cnt=%0d ir=%b want 0 0 0 1",
               out_valid3, sum3, cnt3, in_ready3);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      n_vec++;
      if (out_valid3 !== 1'b0) begin n_err++; $display("FAIL rm_stale got ov=%b want 0", out_valid3); end
    end
  endtask

  task automatic test_wrap();
    logic [2:0] xa, xb;
    bit ig, og;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      xa = 3'($urandom); xb = 3'($urandom); ig = 1'($urandom); og = 1'($urandom);
      send3(xa, xb, ig, og, 4'(model(xa, xb, ig, og)), "wrap_txn");
    end
    n_vec++; if (cnt_c !== 2'd1) begin n_err++; $display("FAIL wrap_cnt got %0d want 1", cnt_c); end
    n_vec++; if (cnt3 !== 16'd5) begin n_err++; $display("FAIL wrap_cnt16 got %0d want 5", cnt3); end
  endtask

  task automatic test_random8();
    logic [8:0] q[$];
    logic [8:0] prev_sum;
    bit prev_stall;
    int sent, got;
    do_reset();
    sent = 0; got = 0; prev_stall = 1'b0; prev_sum = '0;
    for (int c = 0; c < 3000 && got < 100; c++) begin
      in_valid8 = (sent < 100) && ($urandom_range(0, 3) != 0);
      a8 = 8'($urandom); b8 = 8'($urandom); isg8 = 1'($urandom); outg8 = 1'($urandom);
      out_ready8 = ($urandom_range(0, 2) != 0);
      #1;
      if (prev_stall) begin
        n_vec++;
        if (out_valid8 !== 1'b1 || sum8 !== prev_sum) begin
          n_err++; $display("FAIL rnd_hold got ov=%b sum=%h want 1 %h", out_valid8, sum8, prev_sum);
        end
      end
      if (in_valid8 && in_ready8) begin
        q.push_back(9'(model(a8, b8, isg8, outg8)));
        sent++;
      end
      if (out_valid8 && out_ready8) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL rnd_extra got sum=%h want no output", sum8);
        end else begin
          if (sum8 !== q[0]) begin n_err++; $display("FAIL rnd_sum got %h want %h", sum8, q[0]); end
          void'(q.pop_front());
        end
        got++;
      end
      prev_stall = out_valid8 && !out_ready8;
      prev_sum = sum8;
      tick();
    end
    in_valid8 = 1'b0;
    n_vec++; if (got !== 100) begin n_err++; $display("FAIL rnd_got got %0d want 100", got); end
    n_vec++; if (cnt8 !== 16'd100) begin n_err++; $display("FAIL rnd_cnt got %0d want 100", cnt8); end
  endtask

  task automatic test_full_rate();
    logic [8:0] q[$];
    do_reset();
    out_ready8 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid8 = (c < 10);
      a8 = 8'($urandom); b8 = 8'($urandom); isg8 = 1'($urandom); outg8 = 1'($urandom);
      #1;
      n_vec++; if (in_ready8 !== 1'b1) begin n_err++; $display("FAIL fr_ir%0d got %b want 1", c, in_ready8); end
      if (c >= 2) begin
        n_vec++;
        if (out_valid8 !== 1'b1 || q.size() == 0) begin
          n_err++; $display("FAIL fr_ov%0d got %b want 1", c, out_valid8);
        end else begin
          if (sum8 !== q[0]) begin n_err++; $display("FAIL fr_sum%0d got %h want %h", c, sum8, q[0]); end
          void'(q.pop_front());
        end
      end
      if (in_valid8) q.push_back(9'(model(a8, b8, isg8, outg8)));
      tick();
    end
    in_valid8 = 1'b0;
    n_vec++; if (cnt8 !== 16'd10) begin n_err++; $display("FAIL fr_cnt got %0d want 10", cnt8); end
  endtask

  initial begin
    rst = 1'b1;
    in_valid3 = 1'b0; a3 = '0; b3 = '0; isg3 = 1'b0; outg3 = 1'b0; out_ready3 = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; isg8 = 1'b0; outg8 = 1'b0; out_ready8 = 1'b1;
    #1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    test_random8();
    test_full_rate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/magic_adder_pipe.md
Name: magic_adder_pipe

Overview:
- Parametrised, pipelined successor to the 3-bit combinational magic adder.
- Accepts two W-bit operands, each tagged per transaction as binary or Gray-coded, and converts Gray operands to binary.
- Produces a (W+1)-bit sum, optionally re-encoded to Gray.
- Sits between operand producers and result consumers on valid/ready streams, with full throughput and backpressure.

Parameters:
W, 3, operand width in bits (W >= 2); sum width is W+1
CNT_W, 16, width of the completed-transaction counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand transaction present
in_ready  output  1  block can accept a transaction this cycle
a  input  W  operand A
b  input  W  operand B
is_gray  input  1  1: a and b are Gray-coded; 0: a and b are binary
out_gray  input  1  1: emit sum Gray-coded; 0: emit binary; sampled with the operands
out_valid  output  1  sum holds a valid result
out_ready  input  1  consumer accepts the result this cycle
sum  output  W+1  result
txn_count  output  CNT_W  number of results accepted by the consumer, wraps modulo 2^CNT_W

Behaviour:
- One clock domain; reset is synchronous and active-high, named rst, on clock clk.
- Handshake rules:
  - A transfer occurs on a rising edge where valid && ready on that interface.
  - Once out_valid is high, sum is held stable until out_ready is high.
  - in_ready never depends combinationally on in_valid.
- Stage 1 (S1), register capture on input transfer:
  - If is_gray=1, each operand is converted Gray-to-binary: bin[W-1]=g[W-1]; bin[i]=bin[i+1]^g[i] for i=W-2..0.
  - If is_gray=0, operands pass through unchanged.
  - Registered: s1_a, s1_b (binary), s1_outg (out_gray), s1_valid.
- Stage 2 (S2), register on S1 advance:
  - s2_sum = zero-extended s1_a + zero-extended s1_b, in W+1 bits, so no overflow is possible.
  - If s1_outg=1, store the Gray encoding: sum ^ (sum >> 1). Otherwise store binary.
  - Registered: s2_sum, s2_valid.
- Outputs and flow control:
  - sum = s2_sum; out_valid = s2_valid.
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv.
  - Full throughput: one transaction per cycle when out_ready is held high.
- Latency:
  - An input accepted at edge N produces out_valid=1 after edge N+1, i.e. visible in the cycle following edge N+1.
  - This holds when the output is not stalled.
- Stall behaviour:
  - With out_ready=0 and both stages full, in_ready=0 and no state changes.
  - On out_ready returning to 1, results drain in order with no loss or duplication.
- Simultaneous events:
  - When S2 is full and out_ready=1 in the same cycle S1 advances, S2 is overwritten with the new result. This is a legal consume-and-refill.
  - S1 is likewise consumed and refilled in one cycle.
- txn_count:
  - Increments by 1 on each output transfer (out_valid && out_ready).
  - Wraps from 2^CNT_W-1 to 0.
- Reset values:
  - out_valid=0, in_ready=1 (the cycle after reset), sum=0, txn_count=0.
  - All internal valids and data registers are 0.
- Reset mid-operation: any in-flight transactions are discarded, with no output produced for them. rst has priority over all transfers on the same edge.
- Ordering: results always leave in acceptance order; no reordering or merging.

Test Plan:
- Binary add, W=3: a=001, b=010, is_gray=0, out_gray=0, out_ready=1 -> sum=0011 two edges after acceptance; txn_count=1.
- Gray inputs, W=3: a=101 (bin 110), b=011 (bin 010), is_gray=1, out_gray=0 -> sum=1000. Then a=111, b=111, is_gray=1 (bin 5+5) -> sum=1010.
- Gray output: a=111, b=001, is_gray=0, out_gray=1 (binary 1000) -> sum=1100. Check the maximum case a=111, b=111, is_gray=0 -> 1110 binary, with no overflow loss.
- Backpressure: stream 4 transactions back-to-back while out_ready=0:
  - Exactly 2 are accepted, then in_ready=0.
  - sum holds stable for 5 cycles.
  - Release out_ready -> all 4 results appear in order, one per cycle; txn_count=4.
- Throughput and width, W=8: 100 random transactions with random is_gray/out_gray and random out_ready -> every sum matches a scoreboard model; no drops or duplicates; txn_count=100.
- Reset mid-stream: assert rst for 1 cycle with both stages full -> next cycle out_valid=0, sum=0, txn_count=0, in_ready=1; no stale result emerges afterwards. Separately, CNT_W=2 with 5 outputs -> txn_count wraps to 1.
